// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD display converter.
package bcd_pkg;

    // Conversion sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Default geometry: 20-bit binary input, six packed BCD digits out
    localparam int WIDTH_DEF  = 20;
    localparam int DIGITS_DEF = 6;

    // Iteration counter width; must hold 0..WIDTH_DEF
    localparam int CNT_W = 5;

    // Values above DEC_MAX do not fit six digits and are shown as all nines
    localparam logic [23:0] BCD_SAT = 24'h999999;
    localparam int unsigned DEC_MAX = 999999;

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit double-dabble correction: add 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next decade.
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Correction is purely 4-bit; no carry ever leaves the digit
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end
    end

endmodule

// File: rtl/bcd_dabble.sv
// Iterative binary-to-BCD converter for the scanned seven-segment driver.
// One shift-and-add-3 step per clock; the registered result is only
// replaced when a conversion completes, and saturates at 999999.
module bcd_dabble
    import bcd_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  iStart,
    input  logic [WIDTH-1:0]      iDec,
    output logic [4*DIGITS-1:0]   oBcd,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oOvf
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + WIDTH;

    state_t               r_state;
    logic [WORK_W-1:0]    r_work;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ovfPend;
    logic [BCD_W-1:0]     r_bcd;
    logic                 r_ovf;
    logic                 r_done;
    logic                 r_busy;

    state_t               w_stateNext;
    logic [WORK_W-1:0]    w_workNext;
    logic [CNT_W-1:0]     w_cntNext;
    logic                 w_ovfPendNext;
    logic [BCD_W-1:0]     w_bcdNext;
    logic                 w_ovfNext;
    logic                 w_doneNext;
    logic                 w_busyNext;

    logic [BCD_W-1:0]     w_adj;
    logic [WORK_W-1:0]    w_workAdj;

    // One corrector per BCD digit of the working register's upper field
    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_adj
            bcd_digit_adj u_adj (
                .i_digit (r_work[WIDTH + 4*k +: 4]),
                .o_digit (w_adj[4*k +: 4])
            );
        end
    endgenerate

    assign w_workAdj = {w_adj, r_work[WIDTH-1:0]};

    // Next-state and next-register values; everything holds unless a state acts on it
    always_comb begin
        w_stateNext   = r_state;
        w_workNext    = r_work;
        w_cntNext     = r_cnt;
        w_ovfPendNext = r_ovfPend;
        w_bcdNext     = r_bcd;
        w_ovfNext     = r_ovf;
        w_doneNext    = 1'b0;
        case (r_state)
            IDLE: begin
                if (iStart) begin
                    w_workNext    = {{BCD_W{1'b0}}, iDec};
                    w_cntNext     = '0;
                    w_ovfPendNext = (32'(iDec) > DEC_MAX);
                    w_stateNext   = SHIFT;
                end
            end
            SHIFT: begin
                w_workNext = w_workAdj << 1;
                w_cntNext  = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                w_bcdNext   = r_ovfPend ? BCD_W'(BCD_SAT) : r_work[WORK_W-1:WIDTH];
                w_ovfNext   = r_ovfPend;
                w_doneNext  = 1'b1;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
        w_busyNext = (w_stateNext != IDLE);
    end

    // State and datapath registers; synchronous active-low reset aborts any conversion
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_state   <= IDLE;
            r_work    <= '0;
            r_cnt     <= '0;
            r_ovfPend <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_work    <= w_workNext;
            r_cnt     <= w_cntNext;
            r_ovfPend <= w_ovfPendNext;
            r_bcd     <= w_bcdNext;
            r_ovf     <= w_ovfNext;
            r_done    <= w_doneNext;
            r_busy    <= w_busyNext;
        end
    end

    assign oBcd  = r_bcd;
    assign oOvf  = r_ovf;
    assign oDone = r_done;
    assign oBusy = r_busy;

endmodule

// File: tb/tb_bcd_dabble.sv
// Directed and randomized checks of the iterative binary-to-BCD converter.
module tb_bcd_dabble;

    logic        iCLK;
    logic        iRST_N;
    logic        iStart;
    logic [19:0] iDec;
    logic [23:0] oBcd;
    logic        oBusy;
    logic        oDone;
    logic        oOvf;

    int checks   = 0;
    int failures = 0;

    bcd_dabble dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iStart (iStart),
        .iDec   (iDec),
        .oBcd   (oBcd),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oOvf   (oOvf)
    );

    // 10 ns system clock
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference conversion by division, saturating above 999999
    function automatic logic [23:0] refBcd(input int unsigned v);
        logic [23:0] r;
        int unsigned p;
        r = '0;
        if (v > 999999) return 24'h999999;
        p = 1;
        for (int d = 0; d < 6; d++) begin
            r[4*d +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Present a value with a one-cycle start strobe; returns just after the accepting edge
    task automatic applyStimulus(input logic [19:0] value);
        @(negedge iCLK);
        iDec   = value;
        iStart = 1'b1;
        @(posedge iCLK);
        #1 iStart = 1'b0;
    endtask

    // Full conversion with bounded wait for oDone, result and optional timing checks
    task automatic runConversion(input string tag, input logic [19:0] value,
                                 input logic [23:0] expBcd, input logic expOvf, input bit checkTiming);
        int cycles;
        int busyCycles;
        bit seen;
        applyStimulus(value);
        cycles     = 0;
        busyCycles = 0;
        seen       = 1'b0;
        while (!seen && cycles < 40) begin
            @(negedge iCLK);
            cycles++;
            if (oBusy) busyCycles++;
            if (oDone) seen = 1'b1;
        end
        checkOutput({tag, "_doneSeen"}, 32'(seen), 32'd1);
        if (checkTiming) begin
            checkOutput({tag, "_latency"}, 32'(cycles), 32'd22);
            checkOutput({tag, "_busyCycles"}, 32'(busyCycles), 32'd21);
        end
        checkOutput({tag, "_bcd"}, 32'(oBcd), 32'(expBcd));
        checkOutput({tag, "_ovf"}, 32'(oOvf), 32'(expOvf));
        @(negedge iCLK);
        if (checkTiming) begin
            checkOutput({tag, "_donePulseWidth"}, 32'(oDone), 32'd0);
            checkOutput({tag, "_bcdHeld"}, 32'(oBcd), 32'(expBcd));
        end
    endtask

    initial begin
        int gap;
        int doneCount;
        bit seen;
        logic [19:0] rv;

        iRST_N = 1'b0;
        iStart = 1'b0;
        iDec   = '0;

        // Reset values, with a start request that reset must override
        @(negedge iCLK);
        iStart = 1'b1;
        iDec   = 20'd55;
        @(negedge iCLK);
        checkOutput("reset_bcd", 32'(oBcd), 32'd0);
        checkOutput("reset_busy", 32'(oBusy), 32'd0);
        checkOutput("reset_done", 32'(oDone), 32'd0);
        checkOutput("reset_ovf", 32'(oOvf), 32'd0);
        iStart = 1'b0;
        iRST_N = 1'b1;
        @(negedge iCLK);
        checkOutput("postReset_busy", 32'(oBusy), 32'd0);

        // Basic conversion and boundary values
        runConversion("basic123456", 20'd123456, 24'h123456, 1'b0, 1'b1);
        runConversion("zero", 20'd0, 24'h000000, 1'b0, 1'b1);
        runConversion("max999999", 20'd999999, 24'h999999, 1'b0, 1'b1);
        runConversion("ovf1000000", 20'd1000000, 24'h999999, 1'b1, 1'b1);
        runConversion("ovfFFFFF", 20'hFFFFF, 24'h999999, 1'b1, 1'b1);
        runConversion("ovfClears", 20'd7, 24'h000007, 1'b0, 1'b1);

        // Input isolation: new iDec and start strobe during SHIFT are ignored
        applyStimulus(20'd42);
        repeat (5) @(negedge iCLK);
        iDec   = 20'd777;
        iStart = 1'b1;
        @(negedge iCLK);
        iStart = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge iCLK);
            if (oDone) seen = 1'b1;
        end
        checkOutput("isolate_doneSeen", 32'(seen), 32'd1);
        checkOutput("isolate_bcd", 32'(oBcd), 32'h000042);
        doneCount = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge iCLK);
            if (oDone) doneCount++;
        end
        checkOutput("isolate_noSecondDone", 32'(doneCount), 32'd0);
        checkOutput("isolate_idleBusy", 32'(oBusy), 32'd0);

        // Back-to-back: iStart held high, iDec 9 then 10
        @(negedge iCLK);
        iDec   = 20'd9;
        iStart = 1'b1;
        @(posedge iCLK);
        #1 iDec = 20'd10;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge iCLK);
            if (oDone) seen = 1'b1;
        end
        checkOutput("b2b_firstDone", 32'(seen), 32'd1);
        checkOutput("b2b_firstBcd", 32'(oBcd), 32'h000009);
        seen = 1'b0;
        gap  = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge iCLK);
            gap++;
            if (oDone) seen = 1'b1;
        end
        iStart = 1'b0;
        checkOutput("b2b_secondDone", 32'(seen), 32'd1);
        checkOutput("b2b_gap", 32'(gap), 32'd22);
        checkOutput("b2b_secondBcd", 32'(oBcd), 32'h000010);
        repeat (3) @(negedge iCLK);
        checkOutput("b2b_stopped", 32'(oBusy), 32'd0);

        // Reset mid-conversion aborts with no done pulse and clears the result
        applyStimulus(20'd321);
        repeat (9) @(negedge iCLK);
        iRST_N = 1'b0;
        @(negedge iCLK);
        checkOutput("midReset_bcd", 32'(oBcd), 32'd0);
        checkOutput("midReset_busy", 32'(oBusy), 32'd0);
        checkOutput("midReset_done", 32'(oDone), 32'd0);
        iRST_N = 1'b1;
        doneCount = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge iCLK);
            if (oDone) doneCount++;
        end
        checkOutput("midReset_noDone", 32'(doneCount), 32'd0);
        runConversion("afterReset500", 20'd500, 24'h000500, 1'b0, 1'b1);

        // Randomized sweep against the division model
        for (int n = 0; n < 1000; n++) begin
            rv = 20'($urandom_range(0, 20'hFFFFF));
            runConversion("rand", rv, refBcd(32'(rv)), (32'(rv) > 999999), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
